median_stream_filter: RTL and testbench



---
 rtl/median_stream_pkg.sv | 33 +++
 rtl/median_rank_select.sv | 45 ++++
 rtl/median_stream_filter.sv | 125 ++++++++++++
 tb/tb_median_stream_filter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/median_stream_pkg.sv
// Shared types and sizing helpers for the streaming median filter.
package median_stream_pkg;

    localparam int DEFAULT_WINDOW    = 3;
    localparam int DEFAULT_FRAME_LEN = 8533;

    // Bits needed to count 0..value-1. The result is never below 1, so that a
    // counter of a degenerate range still has a legal width.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    // Fill counter range is 0..WINDOW-1.
    function automatic int fill_width(input int window);
        return clog2(window);
    endfunction

    // Sample index range is 0..FRAME_LEN-1.
    function automatic int idx_width(input int frame_len);
        return clog2(frame_len);
    endfunction

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fill_state_e;

endpackage

// File: rtl/median_rank_select.sv
// Combinational rank-based median picker over a flattened window of samples.
// Entry 0 is the lowest position index; ties are broken by position so that
// every entry gets a distinct rank and exactly one entry matches the middle.
module median_rank_select #(
    parameter int WIDTH  = 32,
    parameter int WINDOW = 3,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WINDOW*WIDTH-1:0] samples,
    output logic [WIDTH-1:0]        median
);

    localparam int MID = (WINDOW - 1) / 2;

    int rank [WINDOW];

    function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED) begin
            return $signed(a) < $signed(b);
        end
        return a < b;
    endfunction

    // Rank every entry, then forward the one whose rank is the middle.
    always_comb begin
        median = '0;
        for (int i = 0; i < WINDOW; i++) begin
            rank[i] = 0;
            for (int j = 0; j < WINDOW; j++) begin
                if (j != i) begin
                    if (less_than(samples[j*WIDTH +: WIDTH], samples[i*WIDTH +: WIDTH]) ||
                        ((samples[j*WIDTH +: WIDTH] == samples[i*WIDTH +: WIDTH]) && (j < i))) begin
                        rank[i] = rank[i] + 1;
                    end
                end
            end
        end
        for (int i = 0; i < WINDOW; i++) begin
            if (rank[i] == MID) begin
                median = samples[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/median_stream_filter.sv
// Streaming sliding-window median filter with frame-aligned windows.
// The newest sample bypasses the window registers straight into the selector,
// so the median is ready on the same edge that accepts the completing sample.
module median_stream_filter
    import median_stream_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int WINDOW    = DEFAULT_WINDOW,
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter bit SIGNED    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             frame_done,
    output logic             busy
);

    localparam int FILL_W = fill_width(WINDOW);
    localparam int IDX_W  = idx_width(FRAME_LEN);
    localparam int HIST   = (WINDOW > 1) ? WINDOW - 1 : 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_LEN - 1);
    // A one-entry window never needs filling, so it lives in RUN permanently.
    localparam fill_state_e START_STATE = (WINDOW == 1) ? RUN : FILL;

    if ((WINDOW < 1) || ((WINDOW % 2) == 0)) begin : g_bad_window
        $error("median_stream_filter: WINDOW must be odd and at least 1");
    end
    if (FRAME_LEN < WINDOW) begin : g_bad_frame
        $error("median_stream_filter: FRAME_LEN must not be smaller than WINDOW");
    end

    logic [WIDTH-1:0]        win [HIST];
    logic [FILL_W-1:0]       fill;
    logic [IDX_W-1:0]        idx;
    fill_state_e             state;
    logic                    accept;
    logic                    frame_end;
    logic [WINDOW*WIDTH-1:0] cand;
    logic [WIDTH-1:0]        median;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign frame_end = (idx == IDX_LAST);
    assign busy      = (fill != '0) || out_valid;

    // Candidate set: incoming sample at position 0, then the held history.
    always_comb begin
        cand = '0;
        cand[WIDTH-1:0] = in_data;
        for (int i = 1; i < WINDOW; i++) begin
            cand[i*WIDTH +: WIDTH] = win[i-1];
        end
    end

    median_rank_select #(
        .WIDTH  (WIDTH),
        .WINDOW (WINDOW),
        .SIGNED (SIGNED)
    ) u_select (
        .samples (cand),
        .median  (median)
    );

    // Shift the history on every accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < HIST; i++) begin
                win[i] <= '0;
            end
        end else if (accept) begin
            win[0] <= in_data;
            for (int i = 1; i < HIST; i++) begin
                win[i] <= win[i-1];
            end
        end
    end

    // Fill/run sequencing, frame index tracking and the single output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= START_STATE;
            fill       <= '0;
            idx        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && out_last;
            if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (accept) begin
                idx <= frame_end ? '0 : idx + 1'b1;
                case (state)
                    FILL: begin
                        fill <= fill + 1'b1;
                        if (fill + 1'b1 == FILL_FULL) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        out_valid <= 1'b1;
                        out_data  <= median;
                        out_last  <= frame_end;
                        if (frame_end) begin
                            fill  <= '0;
                            state <= START_STATE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_median_stream_filter.sv
// Directed bench for median_stream_filter: three instances cover the
// FRAME_LEN=5/WINDOW=3 unsigned case, WINDOW=5 and a signed WINDOW=3 case.
module tb_median_stream_filter;

    localparam int W  = 32;
    localparam int ND = 3;

    int win_of  [ND] = '{3, 5, 3};
    int flen_of [ND] = '{5, 8533, 8533};
    bit sgn_of  [ND] = '{1'b0, 1'b0, 1'b1};
    int fd_total[ND] = '{5, 0, 0};

    logic         clk = 1'b0;
    logic         rst;
    logic         out_ready;
    logic [W-1:0] in_data;
    logic         in_valid   [ND];
    logic         in_ready   [ND];
    logic         out_valid  [ND];
    logic [W-1:0] out_data   [ND];
    logic         out_last   [ND];
    logic         frame_done [ND];
    logic         busy       [ND];

    median_stream_filter #(.WIDTH(W), .WINDOW(3), .FRAME_LEN(5), .SIGNED(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .out_last(out_last[0]), .frame_done(frame_done[0]), .busy(busy[0]));

    median_stream_filter #(.WIDTH(W), .WINDOW(5), .FRAME_LEN(8533), .SIGNED(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .out_last(out_last[1]), .frame_done(frame_done[1]), .busy(busy[1]));

    median_stream_filter #(.WIDTH(W), .WINDOW(3), .FRAME_LEN(8533), .SIGNED(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_data(out_data[2]),
        .out_last(out_last[2]), .frame_done(frame_done[2]), .busy(busy[2]));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Bench-side reference: history per instance, frame index and expected-output FIFO.
    logic [W-1:0] hist  [ND][5];
    int           hcnt  [ND];
    int           midx  [ND];
    logic [W-1:0] exp_d [ND][64];
    logic         exp_l [ND][64];
    int           wr    [ND];
    int           rd    [ND];
    logic         pend  [ND];
    int           fd_seen [ND];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
        n_checks++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic bit lt_m(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        if (sgn_of[k]) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ND; k++) begin
            hcnt[k] = 0;
            midx[k] = 0;
            rd[k]   = wr[k];
            pend[k] = 1'b0;
        end
    endtask

    task automatic model_accept(input int k, input logic [W-1:0] d,
                                output logic produced, output logic [W-1:0] med, output logic last);
        logic [W-1:0] srt [5];
        logic [W-1:0] t;
        int n;
        n = win_of[k];
        for (int i = 4; i > 0; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = d;
        if (hcnt[k] < n) hcnt[k]++;
        last     = (midx[k] == flen_of[k] - 1);
        produced = (hcnt[k] == n);
        med      = '0;
        if (produced) begin
            for (int i = 0; i < 5; i++) srt[i] = hist[k][i];
            for (int i = 1; i < n; i++) begin
                for (int j = i; j > 0; j--) begin
                    if (lt_m(k, srt[j], srt[j-1])) begin
                        t = srt[j]; srt[j] = srt[j-1]; srt[j-1] = t;
                    end
                end
            end
            med = srt[n/2];
            exp_d[k][wr[k] % 64] = med;
            exp_l[k][wr[k] % 64] = last;
            wr[k]++;
        end
        if (last) begin
            midx[k] = 0;
            hcnt[k] = 0;
        end else begin
            midx[k]++;
        end
    endtask

    // Offer one sample to instance k, wait (bounded) for its accept, then check the load.
    task automatic send(input int k, input logic [W-1:0] d, output int waits);
        logic rdy, produced, last;
        logic [W-1:0] med;
        waits = 0;
        rdy = 1'b0;
        in_valid[k] = 1'b1;
        in_data = d;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            rdy = in_ready[k];
            @(posedge clk);
            #1;
            if (rdy) break;
            waits++;
        end
        in_valid[k] = 1'b0;
        if (!rdy) begin
            chk("accept_timeout", rdy, 1'b1);
        end else begin
            model_accept(k, d, produced, med, last);
            chk("valid_after_accept", out_valid[k], produced);
            if (produced) begin
                chk("data_after_accept", out_data[k], med);
                chk("last_after_accept", out_last[k], last);
            end
        end
    endtask

    // Scoreboard pop on every output handshake, plus frame_done timing.
    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (rst) begin
                pend[k] = 1'b0;
            end else begin
                chk("frame_done", frame_done[k], pend[k]);
                if (frame_done[k]) fd_seen[k]++;
                pend[k] = 1'b0;
                if (out_valid[k] && out_ready) begin
                    chk("sb_nonempty", (rd[k] < wr[k]), 1'b1);
                    if (rd[k] < wr[k]) begin
                        chk("sb_data", out_data[k], exp_d[k][rd[k] % 64]);
                        chk("sb_last", out_last[k], exp_l[k][rd[k] % 64]);
                        pend[k] = exp_l[k][rd[k] % 64];
                        rd[k]++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt;
        for (int k = 0; k < ND; k++) begin
            in_valid[k] = 1'b0;
            wr[k] = 0;
            fd_seen[k] = 0;
            for (int i = 0; i < 5; i++) hist[k][i] = '0;
        end
        model_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < ND; k++) begin
            chk("rst_in_ready", in_ready[k], 1'b1);
            chk("rst_out_valid", out_valid[k], 1'b0);
            chk("rst_out_data", out_data[k], '0);
            chk("rst_out_last", out_last[k], 1'b0);
            chk("rst_frame_done", frame_done[k], 1'b0);
            chk("rst_busy", busy[k], 1'b0);
        end

        // Basic stream, WINDOW=3: medians 5,3,3 with the last one closing the frame.
        send(0, 5, wt); send(0, 1, wt); send(0, 9, wt); send(0, 3, wt); send(0, 3, wt);

        // Two back-to-back frames: 2,3,4 then 8,7,6.
        send(0, 1, wt); send(0, 2, wt); send(0, 3, wt); send(0, 4, wt); send(0, 5, wt);
        send(0, 9, wt); send(0, 8, wt); send(0, 7, wt); send(0, 6, wt); send(0, 5, wt);

        // Backpressure: hold the median of 10,20,30 for four cycles.
        send(0, 10, wt); send(0, 20, wt);
        out_ready = 1'b0;
        send(0, 30, wt);
        in_valid[0] = 1'b1;
        in_data = 40;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready[0], 1'b0);
            chk("stall_valid", out_valid[0], 1'b1);
            chk("stall_data", out_data[0], 32'd20);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(0, 40, wt);
        chk("resume_no_wait", wt, 0);
        send(0, 50, wt);

        // WINDOW=5 single median, never stalled.
        send(1, 10, wt); chk("w5_ready0", wt, 0);
        send(1, 50, wt); chk("w5_ready1", wt, 0);
        send(1, 20, wt); chk("w5_ready2", wt, 0);
        send(1, 40, wt); chk("w5_ready3", wt, 0);
        send(1, 30, wt); chk("w5_ready4", wt, 0);

        // Mid-frame reset discards the partial window.
        send(0, 4, wt); send(0, 4, wt);
        chk("partial_busy", busy[0], 1'b1);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < ND; k++) begin
            chk("post_rst_valid", out_valid[k], 1'b0);
            chk("post_rst_busy", busy[k], 1'b0);
        end
        send(0, 7, wt); send(0, 7, wt); send(0, 7, wt);
        send(0, 1, wt); send(0, 1, wt);

        // Compare mode: unsigned picks 2, signed picks 0.
        send(0, 32'hFFFF_FFFF, wt); send(0, 2, wt); send(0, 0, wt);
        send(2, 32'hFFFF_FFFF, wt); send(2, 2, wt); send(2, 0, wt);

        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < ND; k++) begin
            chk("sb_drained", wr[k] - rd[k], 0);
            chk("frame_done_count", fd_seen[k], fd_total[k]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
